key_ctrl: RTL and testbench

KEY_CTRL -- requirements
Module: key_ctrl

---
 rtl/key_ctrl.sv | 130 +++++++++++++
 tb/tb_key_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/key_ctrl.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, press/release/long-press pulses.
// Long-press detection is compiled in only when KEY_LONG_PRESS_EN is defined.
module key_ctrl #(
  parameter logic [31:0] DEBOUNCE_CNT_VAL   = 32'd1000000,
  parameter logic [31:0] LONG_PRESS_CNT_VAL = 32'd50000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_pin,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  // A zero parameter would make the terminal count underflow, so it behaves as 1.
  localparam logic [31:0] DB_VAL    = (DEBOUNCE_CNT_VAL == 32'd0) ? 32'd1 : DEBOUNCE_CNT_VAL;
  localparam logic [31:0] LONG_VAL  = (LONG_PRESS_CNT_VAL == 32'd0) ? 32'd1 : LONG_PRESS_CNT_VAL;
  localparam logic [31:0] DB_LAST   = DB_VAL - 32'd1;
  localparam logic [31:0] LONG_LAST = LONG_VAL - 32'd1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  state_t      state_q;
  logic        sync_meta_q;
  logic        sync_key_q;
  logic [31:0] db_cnt_q;
  logic        key_state_q;
  logic        key_press_q;
  logic        key_release_q;

  // Synchronizer idles high so a released key looks released straight out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_meta_q <= 1'b1;
      sync_key_q  <= 1'b1;
    end else begin
      sync_meta_q <= key_pin;
      sync_key_q  <= sync_meta_q;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  logic [31:0] long_cnt_q;
  logic        key_long_q;
  assign key_long = key_long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_LAST;
  assign key_long        = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      db_cnt_q      <= 32'd0;
      key_state_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_cnt_q    <= 32'd0;
      key_long_q    <= 1'b0;
`endif
    end else begin
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      key_long_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          db_cnt_q <= 32'd0;
          if (!sync_key_q) state_q <= PRESS_DB;
        end
        PRESS_DB: begin
          if (sync_key_q) begin
            state_q  <= IDLE;
            db_cnt_q <= 32'd0;
          end else if (db_cnt_q >= DB_LAST) begin
            state_q     <= HELD;
            db_cnt_q    <= 32'd0;
            key_state_q <= 1'b1;
            key_press_q <= 1'b1;
`ifdef KEY_LONG_PRESS_EN
            long_cnt_q  <= 32'd0;
`endif
          end else begin
            db_cnt_q <= db_cnt_q + 32'd1;
          end
        end
        HELD: begin
`ifdef KEY_LONG_PRESS_EN
          // Counter saturates above LONG_LAST, so the pulse cannot repeat within one press.
          if (long_cnt_q != 32'hFFFF_FFFF) long_cnt_q <= long_cnt_q + 32'd1;
          if (long_cnt_q == LONG_LAST) key_long_q <= 1'b1;
`endif
          db_cnt_q <= 32'd0;
          if (sync_key_q) state_q <= RELEASE_DB;
        end
        RELEASE_DB: begin
          if (!sync_key_q) begin
            state_q  <= HELD;
            db_cnt_q <= 32'd0;
          end else if (db_cnt_q >= DB_LAST) begin
            state_q       <= IDLE;
            db_cnt_q      <= 32'd0;
            key_state_q   <= 1'b0;
            key_release_q <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          db_cnt_q <= 32'd0;
        end
      endcase
    end
  end

  assign key_state   = key_state_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Self-checking bench for key_ctrl: directed scenarios plus random bursts against a run-length model.
module tb_key_ctrl;

  localparam int D = 4;
  localparam int L = 16;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_pin;
  logic key_state, key_press, key_release, key_long;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  bit mSync1, mSync2, mPressed;
  int mRun, mHeld;
  bit eP, eR, eL;

  int pressSeen, releaseSeen, longSeen;
  int firstPress, firstLong, startCycle;

  key_ctrl #(
    .DEBOUNCE_CNT_VAL  (32'd4),
    .LONG_PRESS_CNT_VAL(32'd16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_pin    (key_pin),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s @cycle %0d: observed %b expected %b", tag, cycle, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s @cycle %0d: observed %0d expected %0d", tag, cycle, obs, exp);
    end
  endtask

  // The accepted level flips once the synchronized pin has shown the opposite level for D+1 edges.
  task automatic modelEdge(input bit pin);
    bit s;
    s      = mSync2;
    mSync2 = mSync1;
    mSync1 = pin;
    eP = 1'b0; eR = 1'b0; eL = 1'b0;
    if (mPressed && mRun == 0) begin
      if (LONG_EN && mHeld == L - 1) eL = 1'b1;
      mHeld++;
    end
    if (mPressed ? s : !s) mRun++;
    else mRun = 0;
    if (mRun == D + 1) begin
      mPressed = !mPressed;
      mRun     = 0;
      if (mPressed) begin
        eP    = 1'b1;
        mHeld = 0;
      end else begin
        eR = 1'b1;
      end
    end
  endtask

  task automatic modelReset();
    mSync1 = 1'b1; mSync2 = 1'b1; mPressed = 1'b0;
    mRun = 0; mHeld = 0;
    eP = 1'b0; eR = 1'b0; eL = 1'b0;
  endtask

  task automatic clearCounts();
    pressSeen = 0; releaseSeen = 0; longSeen = 0;
    firstPress = 0; firstLong = 0;
    startCycle = cycle;
  endtask

  task automatic applyStimulus(input bit pin);
    key_pin = pin;
    @(posedge sys_clk);
    cycle++;
    modelEdge(pin);
    #1;
    if (key_press === 1'b1) begin
      if (pressSeen == 0) firstPress = cycle;
      pressSeen++;
    end
    if (key_release === 1'b1) releaseSeen++;
    if (key_long === 1'b1) begin
      if (longSeen == 0) firstLong = cycle;
      longSeen++;
    end
    checkOutput("key_state", key_state, mPressed);
    checkOutput("key_press", key_press, eP);
    checkOutput("key_release", key_release, eR);
    checkOutput("key_long", key_long, eL);
  endtask

  task automatic hold(input bit pin, input int n);
    for (int i = 0; i < n; i++) applyStimulus(pin);
  endtask

  task automatic doReset();
    sys_rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_key_state", key_state, 1'b0);
    checkOutput("rst_key_press", key_press, 1'b0);
    checkOutput("rst_key_release", key_release, 1'b0);
    checkOutput("rst_key_long", key_long, 1'b0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    sys_rst_n = 1'b1;
    key_pin   = 1'b1;
    modelReset();
    clearCounts();
    #2;
    doReset();
    hold(1'b1, 5);

    // Clean press held 40 cycles, then release.
    clearCounts();
    hold(1'b0, 40);
    checkCount("clean_press_count", pressSeen, 1);
    checkCount("clean_press_edge", firstPress - startCycle, D + 3);
    checkCount("clean_long_count", longSeen, LONG_EN ? 1 : 0);
    hold(1'b1, 10);
    checkCount("clean_release_count", releaseSeen, 1);

    // Press bounce is rejected.
    clearCounts();
    hold(1'b0, 3); hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 10);
    checkCount("bounce_press_count", pressSeen, 0);
    checkCount("bounce_release_count", releaseSeen, 0);

    // Release bounce returns to the held state, a stable release is then accepted.
    hold(1'b0, 10);
    clearCounts();
    hold(1'b1, 2); hold(1'b0, 5);
    checkCount("relbounce_release_count", releaseSeen, 0);
    checkOutput("relbounce_state", key_state, 1'b1);
    hold(1'b1, 9);
    checkCount("relstable_release_count", releaseSeen, 1);
    checkOutput("relstable_state", key_state, 1'b0);

    // Long press held 60 cycles.
    clearCounts();
    hold(1'b0, 60);
    checkCount("long_press_count", pressSeen, 1);
    checkCount("long_long_count", longSeen, LONG_EN ? 1 : 0);
    checkCount("long_gap", (longSeen > 0) ? firstLong - firstPress : -1, LONG_EN ? L : -1);
    hold(1'b1, 10);

    // Reset while held, key still down after release of reset.
    hold(1'b0, 10);
    doReset();
    clearCounts();
    hold(1'b0, 12);
    checkCount("rst_hold_press_count", pressSeen, 1);
    checkCount("rst_hold_press_edge", firstPress - startCycle, D + 3);
    checkCount("rst_hold_release_count", releaseSeen, 0);
    hold(1'b1, 10);

    // Random bursts, occasionally long enough to trigger long press.
    for (int b = 0; b < 60; b++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? 25 : int'($urandom_range(1, 12));
      hold(b[0], len);
    end
    hold(1'b1, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
